// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C transfer sequencer.
package i2c_seq_pkg;

   localparam int ADDR_W          = 7;
   localparam int DATA_W          = 8;

   localparam int DEF_MAX_RETRY   = 3;
   localparam int DEF_LAUNCH_TO   = 4096;
   localparam int DEF_XFER_TO     = 65535;
   localparam int DEF_BACKOFF_CYC = 256;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LAUNCH  = 3'd1,
      ACTIVE  = 3'd2,
      EVAL    = 3'd3,
      BACKOFF = 3'd4,
      RESP    = 3'd5
   } state_e;

   // Largest of three limits; sizes the shared timeout/backoff counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return m;
   endfunction

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchroniser for slow-domain status bits.
module i2c_sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   // Two-stage capture; only sync_q is used downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/i2c_xfer_sequencer.sv
// Command stage in front of the I2C master: launches single-byte transfers,
// supervises them with timeouts, retries failures after a backoff and
// returns exactly one response per accepted request.
module i2c_xfer_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int MAX_RETRY   = DEF_MAX_RETRY,
   parameter int LAUNCH_TO   = DEF_LAUNCH_TO,
   parameter int XFER_TO     = DEF_XFER_TO,
   parameter int BACKOFF_CYC = DEF_BACKOFF_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rnw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic [2:0]        rsp_tries,
   output logic              m_start_o,
   output logic              m_stop_o,
   output logic              m_rnw_o,
   output logic [ADDR_W-1:0] m_addr_o,
   output logic [DATA_W-1:0] m_wdata_o,
   input  logic [DATA_W-1:0] m_rdata_i,
   input  logic              m_busy_i,
   input  logic              m_error_i,
   input  logic              m_success_i
);

   localparam int MAX_CNT = max3(XFER_TO, LAUNCH_TO, BACKOFF_CYC);
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   // Down-counter reload values: the state lasts exactly N cycles.
   localparam logic [CNT_W-1:0] LAUNCH_LD  = CNT_W'(LAUNCH_TO - 1);
   localparam logic [CNT_W-1:0] XFER_LD    = CNT_W'(XFER_TO - 1);
   localparam logic [CNT_W-1:0] BACKOFF_LD = CNT_W'(BACKOFF_CYC - 1);
   // One more than the retry budget; 4 bits so MAX_RETRY=7 still fits.
   localparam logic [3:0]       TRIES_MAX  = 4'(MAX_RETRY + 1);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [3:0]        tries_q;
   logic              tmo_q;

   logic              hold_rnw_q;
   logic [ADDR_W-1:0] hold_addr_q;
   logic [DATA_W-1:0] hold_wdata_q;

   logic              req_ready_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              rsp_err_q;
   logic              rsp_timeout_q;
   logic [2:0]        rsp_tries_q;
   logic              m_start_q;
   logic              m_stop_q;

   logic [2:0]        stat_s;
   logic              busy_s;
   logic              err_s;
   logic              succ_s;

   logic              cnt_zero_s;
   logic [CNT_W-1:0]  cnt_dec_d;
   logic              attempt_ok_s;
   logic              can_retry_s;

   i2c_sync2 #(.W(3)) u_stat_sync (
      .clk (clk),
      .rst (rst),
      .d_i ({m_busy_i, m_error_i, m_success_i}),
      .q_o (stat_s)
   );

   assign {busy_s, err_s, succ_s} = stat_s;

   // Counter expiry and attempt verdict; error wins over success.
   always_comb begin
      cnt_zero_s   = (cnt_q == '0);
      cnt_dec_d    = cnt_q - CNT_W'(1);
      attempt_ok_s = succ_s & ~err_s & ~tmo_q;
      can_retry_s  = (tries_q < TRIES_MAX);
   end

   // Sequencer FSM with registered master controls and response fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         tries_q       <= 4'd0;
         tmo_q         <= 1'b0;
         hold_rnw_q    <= 1'b0;
         hold_addr_q   <= '0;
         hold_wdata_q  <= '0;
         req_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_tries_q   <= 3'd0;
         m_start_q     <= 1'b0;
         m_stop_q      <= 1'b0;
      end else begin
         // Stop is a single-cycle pulse unless re-armed below.
         m_stop_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid && req_ready_q) begin
                  hold_rnw_q   <= req_rnw;
                  hold_addr_q  <= req_addr;
                  hold_wdata_q <= req_wdata;
                  tries_q      <= 4'd1;
                  tmo_q        <= 1'b0;
                  cnt_q        <= LAUNCH_LD;
                  m_start_q    <= 1'b1;
                  req_ready_q  <= 1'b0;
                  state_q      <= LAUNCH;
               end
            end
            LAUNCH: begin
               if (busy_s) begin
                  m_start_q <= 1'b0;
                  cnt_q     <= XFER_LD;
                  state_q   <= ACTIVE;
               end else if (cnt_zero_s) begin
                  m_start_q <= 1'b0;
                  tmo_q     <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= EVAL;
               end else begin
                  cnt_q <= cnt_dec_d;
               end
            end
            ACTIVE: begin
               if (!busy_s) begin
                  cnt_q   <= '0;
                  state_q <= EVAL;
               end else if (cnt_zero_s) begin
                  m_stop_q <= 1'b1;
                  tmo_q    <= 1'b1;
                  cnt_q    <= '0;
                  state_q  <= EVAL;
               end else begin
                  cnt_q <= cnt_dec_d;
               end
            end
            EVAL: begin
               if (attempt_ok_s) begin
                  // Read data is stable here: busy_s has already fallen.
                  rsp_rdata_q   <= hold_rnw_q ? m_rdata_i : '0;
                  rsp_err_q     <= 1'b0;
                  rsp_timeout_q <= 1'b0;
                  rsp_tries_q   <= tries_q[2:0];
                  rsp_valid_q   <= 1'b1;
                  cnt_q         <= '0;
                  state_q       <= RESP;
               end else if (can_retry_s) begin
                  tries_q <= tries_q + 4'd1;
                  cnt_q   <= BACKOFF_LD;
                  state_q <= BACKOFF;
               end else begin
                  rsp_rdata_q   <= '0;
                  rsp_err_q     <= 1'b1;
                  rsp_timeout_q <= tmo_q;
                  rsp_tries_q   <= tries_q[2:0];
                  rsp_valid_q   <= 1'b1;
                  cnt_q         <= '0;
                  state_q       <= RESP;
               end
            end
            BACKOFF: begin
               if (cnt_zero_s) begin
                  tmo_q     <= 1'b0;
                  m_start_q <= 1'b1;
                  cnt_q     <= LAUNCH_LD;
                  state_q   <= LAUNCH;
               end else begin
                  cnt_q <= cnt_dec_d;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               m_start_q   <= 1'b0;
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
               cnt_q       <= '0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
   assign rsp_tries   = rsp_tries_q;
   assign m_start_o   = m_start_q;
   assign m_stop_o    = m_stop_q;
   assign m_rnw_o     = hold_rnw_q;
   assign m_addr_o    = hold_addr_q;
   assign m_wdata_o   = hold_wdata_q;

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Scoreboard bench for i2c_xfer_sequencer with a scripted I2C master model.
module tb_i2c_xfer_sequencer;

   localparam int MAX_RETRY   = 3;
   localparam int LAUNCH_TO   = 16;
   localparam int XFER_TO     = 64;
   localparam int BACKOFF_CYC = 256;
   localparam int N_ATT       = MAX_RETRY + 1;

   // Per-attempt master behaviour
   localparam int OC_OK     = 0;
   localparam int OC_ERR    = 1;
   localparam int OC_NACK   = 2;
   localparam int OC_NOBUSY = 3;
   localparam int OC_STUCK  = 4;

   localparam logic [63:0] RESET_VAL = 64'h0000_0001_0000_0000;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic       req_rnw;
   logic [6:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       rsp_timeout;
   logic [2:0] rsp_tries;
   logic       m_start_o;
   logic       m_stop_o;
   logic       m_rnw_o;
   logic [6:0] m_addr_o;
   logic [7:0] m_wdata_o;
   logic [7:0] m_rdata_i;
   logic       m_busy_i;
   logic       m_error_i;
   logic       m_success_i;

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      logic       tmo;
      logic [2:0] tries;
      int         stops;
   } exp_t;

   exp_t       sb_q[$];
   int         tests = 0;
   int         fails = 0;
   int         plan[N_ATT];
   int         att = 0;
   int         stop_cnt = 0;
   int         cyc = 0;
   int         fall_cyc = 0;
   int         busy_len = 1;
   logic       cur_rnw;
   logic [6:0] cur_addr;
   logic [7:0] cur_wdata;
   logic [7:0] cur_rdata;
   logic       rsp_block = 1'b0;

   i2c_xfer_sequencer #(
      .MAX_RETRY   (MAX_RETRY),
      .LAUNCH_TO   (LAUNCH_TO),
      .XFER_TO     (XFER_TO),
      .BACKOFF_CYC (BACKOFF_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_rnw     (req_rnw),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .rsp_tries   (rsp_tries),
      .m_start_o   (m_start_o),
      .m_stop_o    (m_stop_o),
      .m_rnw_o     (m_rnw_o),
      .m_addr_o    (m_addr_o),
      .m_wdata_o   (m_wdata_o),
      .m_rdata_i   (m_rdata_i),
      .m_busy_i    (m_busy_i),
      .m_error_i   (m_error_i),
      .m_success_i (m_success_i)
   );

   always #5 clk = ~clk;

   // Free-running cycle count for gap measurements
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] pack_outs();
      return {31'b0, req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, rsp_tries,
              m_start_o, m_stop_o, m_rnw_o, m_addr_o, m_wdata_o};
   endfunction

   // Reference: first successful attempt wins; otherwise the budget is spent
   // and the cause of the last attempt decides the timeout flag.
   function automatic exp_t model(input int p[N_ATT], input logic rnw, input logic [7:0] rd);
      exp_t e;
      int   stops;
      stops   = 0;
      e.err   = 1'b1;
      e.tmo   = 1'b0;
      e.rdata = 8'h00;
      e.tries = 3'(N_ATT);
      e.stops = 0;
      for (int i = 0; i < N_ATT; i++) begin
         if (p[i] == OC_OK) begin
            e.err   = 1'b0;
            e.tries = 3'(i + 1);
            e.rdata = rnw ? rd : 8'h00;
            e.stops = stops;
            return e;
         end
         if (p[i] == OC_STUCK) stops++;
      end
      e.tmo   = (p[N_ATT-1] == OC_NOBUSY) || (p[N_ATT-1] == OC_STUCK);
      e.stops = stops;
      return e;
   endfunction

   function automatic int pick_oc();
      int r;
      r = $urandom_range(0, 99);
      if (r < 55) return OC_OK;
      if (r < 70) return OC_ERR;
      if (r < 80) return OC_NACK;
      if (r < 92) return OC_NOBUSY;
      return OC_STUCK;
   endfunction

   task automatic issue(input logic rnw, input logic [6:0] addr, input logic [7:0] wd,
                        input logic [7:0] rd, input int p0, input int p1, input int p2,
                        input int p3, input int blen);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_wait", req_ready, 1);
      plan[0]   = p0;
      plan[1]   = p1;
      plan[2]   = p2;
      plan[3]   = p3;
      att       = 0;
      stop_cnt  = 0;
      cur_rnw   = rnw;
      cur_addr  = addr;
      cur_wdata = wd;
      cur_rdata = rd;
      busy_len  = blen;
      sb_q.push_back(model(plan, rnw, rd));
      req_valid = 1'b1;
      req_rnw   = rnw;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("req_ready_drop", req_ready, 0);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("rsp_arrived", sb_q.size(), 0);
   endtask

   // Master model: plays the planned outcome for each start it observes
   initial begin : master_model
      int oc;
      int n;
      m_busy_i    = 1'b0;
      m_error_i   = 1'b0;
      m_success_i = 1'b0;
      m_rdata_i   = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_busy_i    = 1'b0;
            m_error_i   = 1'b0;
            m_success_i = 1'b0;
         end else if (m_start_o) begin
            if (att > 0) check("start_gap_ge_backoff", (cyc - fall_cyc) >= BACKOFF_CYC, 1);
            check("m_addr_o", m_addr_o, cur_addr);
            check("m_rnw_o", m_rnw_o, cur_rnw);
            check("m_wdata_o", m_wdata_o, cur_wdata);
            oc = (att < N_ATT) ? plan[att] : OC_NOBUSY;
            att++;
            if (oc == OC_NOBUSY) begin
               n = 0;
               while (m_start_o && !rst && n < LAUNCH_TO + 8) begin
                  @(negedge clk);
                  n++;
               end
               if (!rst) check("launch_timeout_len", n, LAUNCH_TO);
            end else begin
               m_error_i   = 1'b0;
               m_success_i = 1'b0;
               m_busy_i    = 1'b1;
               n = 0;
               while (m_start_o && !rst && n < 10) begin
                  @(negedge clk);
                  n++;
               end
               if (!rst) check("start_drop_after_busy", n <= 3, 1);
               if (oc == OC_STUCK) begin
                  n = 0;
                  while (!m_stop_o && !rst && n < XFER_TO + 8) begin
                     @(negedge clk);
                     n++;
                  end
                  if (!rst) begin
                     check("stop_seen", m_stop_o, 1);
                     @(negedge clk);
                     check("stop_one_cycle", m_stop_o, 0);
                  end
                  m_busy_i  = 1'b0;
                  m_error_i = 1'b1;
               end else begin
                  n = 0;
                  while (!rst && n < busy_len) begin
                     @(negedge clk);
                     n++;
                  end
                  if (!rst) check("m_addr_stable", m_addr_o, cur_addr);
                  m_rdata_i   = cur_rdata;
                  m_success_i = (oc == OC_OK);
                  m_error_i   = (oc == OC_ERR);
                  m_busy_i    = 1'b0;
               end
            end
            fall_cyc = cyc;
         end
      end
   end

   // Count every stop pulse seen by the master
   initial begin : stop_counter
      forever begin
         @(negedge clk);
         if (!rst && m_stop_o) stop_cnt++;
      end
   end

   // Response back-pressure
   initial begin : rsp_ready_drv
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1 rsp_ready = !rsp_block && ($urandom_range(0, 3) != 0);
      end
   end

   // Response monitor: pops the scoreboard on each response handshake
   initial begin : rsp_monitor
      exp_t        e;
      logic        held;
      logic [12:0] snap;
      held = 1'b0;
      snap = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            held = 1'b0;
         end else if (rsp_valid) begin
            if (held) check("rsp_stable", {rsp_rdata, rsp_err, rsp_timeout, rsp_tries}, snap);
            if (rsp_ready) begin
               if (sb_q.size() == 0) begin
                  check("rsp_unexpected", sb_q.size(), 1);
               end else begin
                  e = sb_q.pop_front();
                  check("rsp_rdata", rsp_rdata, e.rdata);
                  check("rsp_err", rsp_err, e.err);
                  check("rsp_timeout", rsp_timeout, e.tmo);
                  check("rsp_tries", rsp_tries, e.tries);
                  check("start_count", att, e.tries);
                  check("stop_pulses", stop_cnt, e.stops);
               end
               held = 1'b0;
            end else begin
               held = 1'b1;
               snap = {rsp_rdata, rsp_err, rsp_timeout, rsp_tries};
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_rnw   = 1'b0;
      req_addr  = 7'h00;
      req_wdata = 8'h00;
      cur_rnw   = 1'b0;
      cur_addr  = 7'h00;
      cur_wdata = 8'h00;
      cur_rdata = 8'h00;
      for (int i = 0; i < N_ATT; i++) plan[i] = OC_OK;
      repeat (3) @(negedge clk);
      check("reset_outputs", pack_outs(), RESET_VAL);
      rst = 1'b0;

      // Plain write: write data must not leak into rsp_rdata
      issue(1'b0, 7'h50, 8'hA5, 8'h77, OC_OK, OC_OK, OC_OK, OC_OK, 40);
      wait_done();
      // Plain read
      issue(1'b1, 7'h21, 8'h00, 8'h3C, OC_OK, OC_OK, OC_OK, OC_OK, 20);
      wait_done();
      // Two errors then success
      issue(1'b0, 7'h12, 8'h5A, 8'h00, OC_ERR, OC_ERR, OC_OK, OC_OK, 10);
      wait_done();
      // Master never goes busy: launch timeouts exhaust the retries
      issue(1'b0, 7'h0F, 8'h11, 8'h00, OC_NOBUSY, OC_NOBUSY, OC_NOBUSY, OC_NOBUSY, 5);
      wait_done();
      // Busy stuck: one stop pulse per attempt
      issue(1'b1, 7'h7F, 8'h00, 8'hEE, OC_STUCK, OC_STUCK, OC_STUCK, OC_STUCK, 5);
      wait_done();
      // Mixed failures ending in a non-timeout failure
      issue(1'b1, 7'h2A, 8'h00, 8'h55, OC_NACK, OC_NOBUSY, OC_ERR, OC_NACK, 8);
      wait_done();

      // Reset during ACTIVE with the response side stalled
      rsp_block = 1'b1;
      issue(1'b1, 7'h33, 8'h00, 8'h99, OC_STUCK, OC_OK, OC_OK, OC_OK, 5);
      n = 0;
      while (!m_busy_i && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("busy_before_reset", m_busy_i, 1);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_outputs", pack_outs(), RESET_VAL);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst       = 1'b0;
      rsp_block = 1'b0;
      issue(1'b1, 7'h44, 8'h00, 8'hC3, OC_OK, OC_OK, OC_OK, OC_OK, 15);
      wait_done();

      // Randomised traffic
      for (int i = 0; i < 30; i++) begin
         issue(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), pick_oc(), pick_oc(), pick_oc(), pick_oc(),
               $urandom_range(1, 40));
         wait_done();
      end

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
